// File: rtl/mem_wb_stage_if.sv
// MEM -> WB pipeline bus: MEM-stage write-back candidates in, registered WB-stage view out.
// The stage connects to the slave modport; the MEM-side driver uses the master modport.
interface mem_wb_stage_if #(
    parameter int unsigned COUNT_WIDTH = 32
);
    logic                   stall;
    logic                   flush;
    logic                   in_valid;
    logic                   in_reg_write;
    logic [4:0]             in_rd;
    logic [1:0]             in_wb_sel;
    logic [2:0]             in_funct3;
    logic [31:0]            in_alu_result;
    logic [31:0]            in_mem_rdata;
    logic [31:0]            in_pc_plus4;
    logic [31:0]            in_imm;

    logic                   wb_valid;
    logic                   wb_reg_write;
    logic [4:0]             wb_rd;
    logic [1:0]             wb_sel;
    logic [31:0]            wb_alu_result;
    logic [31:0]            wb_load_data;
    logic [31:0]            wb_pc_plus4;
    logic [31:0]            wb_imm;
    logic [COUNT_WIDTH-1:0] retire_count;

    modport slave (
        input  stall, flush, in_valid, in_reg_write, in_rd, in_wb_sel, in_funct3,
               in_alu_result, in_mem_rdata, in_pc_plus4, in_imm,
        output wb_valid, wb_reg_write, wb_rd, wb_sel, wb_alu_result, wb_load_data,
               wb_pc_plus4, wb_imm, retire_count
    );

    modport master (
        output stall, flush, in_valid, in_reg_write, in_rd, in_wb_sel, in_funct3,
               in_alu_result, in_mem_rdata, in_pc_plus4, in_imm,
        input  wb_valid, wb_reg_write, wb_rd, wb_sel, wb_alu_result, wb_load_data,
               wb_pc_plus4, wb_imm, retire_count
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register for the RV32I core: load alignment, x0 write suppression,
// stall/flush handling and a wrapping retired-instruction counter.
module mem_wb_stage #(
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    mem_wb_stage_if.slave  bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;
    localparam int unsigned SW   = 2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic                   valid_q,     valid_d;
    logic                   reg_write_q, reg_write_d;
    logic [RW-1:0]          rd_q,        rd_d;
    logic [SW-1:0]          sel_q,       sel_d;
    logic [XLEN-1:0]        alu_q,       alu_d;
    logic [XLEN-1:0]        load_q,      load_d;
    logic [XLEN-1:0]        pc4_q,       pc4_d;
    logic [XLEN-1:0]        imm_q,       imm_d;
    logic [COUNT_WIDTH-1:0] cnt_q,       cnt_d;

    logic [7:0]             ld_byte_c;
    logic [15:0]            ld_half_c;
    logic [XLEN-1:0]        ld_aligned_c;

    // Byte/halfword extraction by address offset; bit 0 is ignored for halfwords.
    always_comb begin
        ld_byte_c = 8'h00;
        unique case (bus.in_alu_result[1:0])
            2'd0:    ld_byte_c = bus.in_mem_rdata[7:0];
            2'd1:    ld_byte_c = bus.in_mem_rdata[15:8];
            2'd2:    ld_byte_c = bus.in_mem_rdata[23:16];
            default: ld_byte_c = bus.in_mem_rdata[31:24];
        endcase
        ld_half_c = bus.in_alu_result[1] ? bus.in_mem_rdata[31:16] : bus.in_mem_rdata[15:0];
    end

    // Width/sign handling; undefined load codes pass the raw word through.
    always_comb begin
        ld_aligned_c = bus.in_mem_rdata;
        unique case (bus.in_funct3)
            F3_LB:   ld_aligned_c = {{24{ld_byte_c[7]}}, ld_byte_c};
            F3_LH:   ld_aligned_c = {{16{ld_half_c[15]}}, ld_half_c};
            F3_LW:   ld_aligned_c = bus.in_mem_rdata;
            F3_LBU:  ld_aligned_c = {24'h000000, ld_byte_c};
            F3_LHU:  ld_aligned_c = {16'h0000, ld_half_c};
            default: ld_aligned_c = bus.in_mem_rdata;
        endcase
    end

    // Next-state: flush bubbles the control bits only, stall holds everything.
    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        rd_d        = rd_q;
        sel_d       = sel_q;
        alu_d       = alu_q;
        load_d      = load_q;
        pc4_d       = pc4_q;
        imm_d       = imm_q;
        cnt_d       = cnt_q;

        if (bus.flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
        end else if (!bus.stall) begin
            valid_d     = bus.in_valid;
            reg_write_d = bus.in_valid & bus.in_reg_write & (bus.in_rd != 5'd0);
            rd_d        = bus.in_rd;
            sel_d       = bus.in_wb_sel;
            alu_d       = bus.in_alu_result;
            load_d      = ld_aligned_c;
            pc4_d       = bus.in_pc_plus4;
            imm_d       = bus.in_imm;
            if (bus.in_valid) begin
                cnt_d = cnt_q + COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            sel_q       <= '0;
            alu_q       <= '0;
            load_q      <= '0;
            pc4_q       <= '0;
            imm_q       <= '0;
            cnt_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            sel_q       <= sel_d;
            alu_q       <= alu_d;
            load_q      <= load_d;
            pc4_q       <= pc4_d;
            imm_q       <= imm_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.wb_valid      = valid_q;
    assign bus.wb_reg_write  = reg_write_q;
    assign bus.wb_rd         = rd_q;
    assign bus.wb_sel        = sel_q;
    assign bus.wb_alu_result = alu_q;
    assign bus.wb_load_data  = load_q;
    assign bus.wb_pc_plus4   = pc4_q;
    assign bus.wb_imm        = imm_q;
    assign bus.retire_count  = cnt_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: table of load/control vectors plus directed stall, flush,
// asynchronous reset and counter-wrap sequences, on a 4-bit retire counter.
module tb_mem_wb_stage;
    localparam int unsigned CW = 4;
    localparam int unsigned NV = 18;

    typedef struct {
        logic        valid;
        logic        reg_write;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [2:0]  funct3;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] exp_load;
        logic        exp_rw;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [CW-1:0] exp_cnt;
    vec_t vecs [NV];

    mem_wb_stage_if #(.COUNT_WIDTH(CW)) bus ();

    mem_wb_stage #(.COUNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " wb_valid"},      32'(bus.wb_valid),      32'h0);
        chk({tag, " wb_reg_write"},  32'(bus.wb_reg_write),  32'h0);
        chk({tag, " wb_rd"},         32'(bus.wb_rd),         32'h0);
        chk({tag, " wb_sel"},        32'(bus.wb_sel),        32'h0);
        chk({tag, " wb_alu_result"}, bus.wb_alu_result,      32'h0);
        chk({tag, " wb_load_data"},  bus.wb_load_data,       32'h0);
        chk({tag, " wb_pc_plus4"},   bus.wb_pc_plus4,        32'h0);
        chk({tag, " wb_imm"},        bus.wb_imm,             32'h0);
        chk({tag, " retire_count"},  32'(bus.retire_count),  32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                         input logic [1:0] sel, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] rdata);
        bus.in_valid      = v;
        bus.in_reg_write  = rw;
        bus.in_rd         = rd;
        bus.in_wb_sel     = sel;
        bus.in_funct3     = f3;
        bus.in_alu_result = alu;
        bus.in_mem_rdata  = rdata;
        bus.in_pc_plus4   = alu ^ 32'h0000_4444;
        bus.in_imm        = alu ^ 32'hABC0_0000;
    endtask

    function automatic vec_t mk(input logic v, input logic rw, input logic [4:0] rd,
                                input logic [1:0] sel, input logic [2:0] f3,
                                input logic [31:0] alu, input logic [31:0] rdata,
                                input logic [31:0] el, input logic erw);
        vec_t r;
        r.valid = v; r.reg_write = rw; r.rd = rd; r.sel = sel; r.funct3 = f3;
        r.alu = alu; r.rdata = rdata; r.exp_load = el; r.exp_rw = erw;
        return r;
    endfunction

    initial begin
        logic [31:0] rd_w;
        rd_w = 32'h80FF_7F01;
        vecs[0]  = mk(1, 1, 5'd1,  2'd1, 3'b000, 32'h1000, rd_w, 32'h0000_0001, 1);
        vecs[1]  = mk(1, 1, 5'd2,  2'd1, 3'b000, 32'h1001, rd_w, 32'h0000_007F, 1);
        vecs[2]  = mk(1, 1, 5'd3,  2'd1, 3'b000, 32'h1002, rd_w, 32'hFFFF_FFFF, 1);
        vecs[3]  = mk(1, 1, 5'd4,  2'd1, 3'b000, 32'h1003, rd_w, 32'hFFFF_FF80, 1);
        vecs[4]  = mk(1, 1, 5'd5,  2'd1, 3'b100, 32'h2000, rd_w, 32'h0000_0001, 1);
        vecs[5]  = mk(1, 1, 5'd6,  2'd1, 3'b100, 32'h2001, rd_w, 32'h0000_007F, 1);
        vecs[6]  = mk(1, 1, 5'd7,  2'd1, 3'b100, 32'h2002, rd_w, 32'h0000_00FF, 1);
        vecs[7]  = mk(1, 1, 5'd8,  2'd1, 3'b100, 32'h2003, rd_w, 32'h0000_0080, 1);
        vecs[8]  = mk(1, 1, 5'd9,  2'd1, 3'b001, 32'h3000, rd_w, 32'h0000_7F01, 1);
        vecs[9]  = mk(1, 1, 5'd10, 2'd1, 3'b001, 32'h3002, rd_w, 32'hFFFF_80FF, 1);
        vecs[10] = mk(1, 1, 5'd11, 2'd1, 3'b101, 32'h4000, rd_w, 32'h0000_7F01, 1);
        vecs[11] = mk(1, 1, 5'd12, 2'd1, 3'b101, 32'h4002, rd_w, 32'h0000_80FF, 1);
        vecs[12] = mk(1, 1, 5'd13, 2'd1, 3'b001, 32'h3001, rd_w, 32'h0000_7F01, 1);
        vecs[13] = mk(1, 1, 5'd14, 2'd1, 3'b010, 32'h5003, rd_w, 32'h80FF_7F01, 1);
        vecs[14] = mk(1, 1, 5'd15, 2'd0, 3'b011, 32'h6001, rd_w, 32'h80FF_7F01, 1);
        vecs[15] = mk(1, 0, 5'd16, 2'd3, 3'b110, 32'h7002, rd_w, 32'h80FF_7F01, 0);
        vecs[16] = mk(1, 1, 5'd0,  2'd2, 3'b000, 32'h8000, rd_w, 32'h0000_0001, 0);
        vecs[17] = mk(0, 1, 5'd17, 2'd0, 3'b111, 32'h9000, rd_w, 32'h80FF_7F01, 0);

        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(1, 1, 5'd21, 2'd3, 3'b000, 32'hDEAD_BEEF, 32'hFFFF_FFFF);

        // Power-on reset with live inputs: outputs must be zero while held.
        step();
        step();
        chk_all_zero("por");
        rst = 1'b0;
        exp_cnt = '0;

        for (int i = 0; i < int'(NV); i++) begin
            drive(vecs[i].valid, vecs[i].reg_write, vecs[i].rd, vecs[i].sel,
                  vecs[i].funct3, vecs[i].alu, vecs[i].rdata);
            step();
            if (vecs[i].valid) exp_cnt = exp_cnt + 1'b1;
            chk($sformatf("v%0d wb_load_data", i), bus.wb_load_data, vecs[i].exp_load);
            chk($sformatf("v%0d wb_reg_write", i), 32'(bus.wb_reg_write), 32'(vecs[i].exp_rw));
            chk($sformatf("v%0d wb_valid", i), 32'(bus.wb_valid), 32'(vecs[i].valid));
            chk($sformatf("v%0d wb_sel", i), 32'(bus.wb_sel), 32'(vecs[i].sel));
            chk($sformatf("v%0d wb_rd", i), 32'(bus.wb_rd), 32'(vecs[i].rd));
            chk($sformatf("v%0d wb_alu_result", i), bus.wb_alu_result, vecs[i].alu);
            chk($sformatf("v%0d wb_pc_plus4", i), bus.wb_pc_plus4, vecs[i].alu ^ 32'h0000_4444);
            chk($sformatf("v%0d wb_imm", i), bus.wb_imm, vecs[i].alu ^ 32'hABC0_0000);
            chk($sformatf("v%0d retire_count", i), 32'(bus.retire_count), 32'(exp_cnt));
        end

        // Load rd=5, then stall three cycles with different inputs presented.
        drive(1, 1, 5'd5, 2'd2, 3'b010, 32'h0000_00A5, 32'h1234_5678);
        step();
        exp_cnt = exp_cnt + 1'b1;
        chk("ld5 wb_rd", 32'(bus.wb_rd), 32'd5);
        chk("ld5 retire_count", 32'(bus.retire_count), 32'(exp_cnt));
        bus.stall = 1'b1;
        drive(1, 1, 5'd9, 2'd1, 3'b000, 32'h0000_0F0F, 32'hCAFE_F00D);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("stall%0d wb_rd", c), 32'(bus.wb_rd), 32'd5);
            chk($sformatf("stall%0d wb_valid", c), 32'(bus.wb_valid), 32'd1);
            chk($sformatf("stall%0d wb_reg_write", c), 32'(bus.wb_reg_write), 32'd1);
            chk($sformatf("stall%0d wb_sel", c), 32'(bus.wb_sel), 32'd2);
            chk($sformatf("stall%0d wb_alu_result", c), bus.wb_alu_result, 32'h0000_00A5);
            chk($sformatf("stall%0d wb_load_data", c), bus.wb_load_data, 32'h1234_5678);
            chk($sformatf("stall%0d retire_count", c), 32'(bus.retire_count), 32'(exp_cnt));
        end

        // Flush together with stall: bubble inserted, data and rd held.
        bus.flush = 1'b1;
        step();
        chk("flush wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("flush wb_reg_write", 32'(bus.wb_reg_write), 32'd0);
        chk("flush wb_rd", 32'(bus.wb_rd), 32'd5);
        chk("flush wb_alu_result", bus.wb_alu_result, 32'h0000_00A5);
        chk("flush retire_count", 32'(bus.retire_count), 32'(exp_cnt));

        // Flush alone with a valid input: still a bubble, not counted.
        bus.stall = 1'b0;
        step();
        chk("flush2 wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("flush2 wb_rd", 32'(bus.wb_rd), 32'd5);
        chk("flush2 retire_count", 32'(bus.retire_count), 32'(exp_cnt));

        // Restore a live state, then assert reset between edges mid-stall.
        bus.flush = 1'b0;
        step();
        exp_cnt = exp_cnt + 1'b1;
        chk("post-flush wb_rd", 32'(bus.wb_rd), 32'd9);
        chk("post-flush retire_count", 32'(bus.retire_count), 32'(exp_cnt));
        bus.stall = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        chk_all_zero("async");
        #1;
        rst = 1'b0;
        bus.stall = 1'b0;

        // Counter wrap: 17 back-to-back valid instructions from zero.
        exp_cnt = '0;
        for (int k = 1; k <= 17; k++) begin
            drive(1, 1, 5'(k), 2'd0, 3'b010, 32'(k), 32'(k));
            step();
            exp_cnt = exp_cnt + 1'b1;
            chk($sformatf("wrap%0d retire_count", k), 32'(bus.retire_count), 32'(exp_cnt));
            chk($sformatf("wrap%0d wb_alu_result", k), bus.wb_alu_result, 32'(k));
        end
        chk("wrap final value", 32'(bus.retire_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
